bcd_seg_display: RTL and testbench
==================================

Name: bcd_seg_display

Overview:
- Downstream display stage for the ALU datapath.
- Takes an N-bit binary result on a load pulse and converts it to decimal with an iterative shift-add-3 (double-dabble) sequencer.
- Drives four active-low seven-segment digits with leading-zero blanking.
- Raises busy/done handshake flags so the ALU control can sequence updates.

Parameters:
- N, 8, width of the binary input value; legal range 1..16.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- value  input  N  binary value to display; sampled only on an accepted load
- load  input  1  start conversion; accepted only in IDLE
- busy  output  1  high while state is not IDLE
- done  output  1  one-cycle pulse when new segment values are valid
- overflow  output  1  high when the last value does not fit in 4 digits; held until next done
- segs1  output  7  ones digit; bit6..bit0 = g,f,e,d,c,b,a; active-low
- segs2  output  7  tens digit, same encoding
- segs3  output  7  hundreds digit, same encoding
- segs4  output  7  thousands digit, same encoding

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; overflow=0; segs1..segs4=7'h7F (all off); internal shift and BCD registers cleared. Reset mid-conversion aborts immediately with no done pulse.
- Glyph encodings:
  - digits 0..9 = 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  - blank = 7'h7F; dash = 7'h3F
- FSM states: IDLE, SHIFT, ENCODE.
- IDLE, load=1 at edge k:
  - latch value into shift register
  - clear 20-bit BCD accumulator (5 nibbles)
  - count=N; go to SHIFT
- SHIFT, edges k+1..k+N, one bit per edge:
  - every BCD nibble >=5 gets +3 (combinational, before the shift)
  - {bcd,shreg} shifts left 1
  - count decrements; when it reaches 0, go to ENCODE
- ENCODE, edge k+N+1:
  - register segs1..segs4 and overflow; done=1 for exactly that one cycle; go to IDLE
- Latency: done is high in the cycle following edge k+N+1, i.e. N+1 cycles after load is sampled (9 for N=8). busy=1 from edge k+1 through edge k+N+1 inclusive.
- Segment outputs change only at the ENCODE edge and hold between conversions.
- Leading-zero blanking: digits above the most significant nonzero digit show blank. Value 0 shows 7'h40 on segs1 and blank on segs2..segs4.
- Overflow: set if the 5th BCD nibble is nonzero (value >9999). All four digits then show dash. Cannot occur for N<=13.
- load while busy: ignored, with no effect on the conversion in progress. load held high: a new conversion starts in the cycle after returning to IDLE (edge k+N+2).
- value changes during a conversion have no effect.

Optional Feature:
- Macro SIGNED_DISPLAY_EN.
- Defined:
  - value is two's complement; a negative value converts its N-bit magnitude (for N=8, -128 gives 128).
  - dash is placed in the digit immediately left of the most significant magnitude digit.
  - if the magnitude needs all 4 digits, or exceeds 9999, overflow=1 and all digits show dash.
  - positive values behave as unsigned.
  - latency is unchanged (magnitude is computed at load).
- Undefined: value is unsigned; no sign logic is synthesized.

Test Plan:
- N=8, value=8'b00101101, load pulse -> done exactly 9 cycles later; segs1=7'h12, segs2=7'h19, segs3=segs4=7'h7F; overflow=0.
- value=8'b11110000 (unsigned build) -> segs1=7'h40, segs2=7'h19, segs3=7'h24, segs4=7'h7F.
- value=0 -> segs1=7'h40, segs2..4=7'h7F; value=255 -> 7'h12, 7'h12, 7'h24, 7'h7F.
- load=1 again 3 cycles into a conversion of 45 (new value 99) -> ignored; single done with 45 displayed, busy continuous. Then assert rst mid-conversion -> busy=0 and segs all 7'h7F immediately; no done.
- SIGNED_DISPLAY_EN, value=8'hF0 (-16) -> segs1=7'h02, segs2=7'h79, segs3=7'h3F, segs4=7'h7F.
- N=16, value=12345 -> overflow=1 and segs1..4=7'h3F; then value=9999 -> overflow=0 and segs all 7'h10.

Source files
------------

// File: rtl/bcd_seg_display.sv
// ============================================================================
// Module   : bcd_seg_display
// Purpose  : Binary-to-BCD (double-dabble) converter driving four active-low
//            seven-segment digits with leading-zero blanking.
//            Optional macro SIGNED_DISPLAY_EN: two's-complement input with sign dash.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_seg_display #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] value,
   input  logic         load,
   output logic         busy,
   output logic         done,
   output logic         overflow,
   output logic [6:0]   segs1,
   output logic [6:0]   segs2,
   output logic [6:0]   segs3,
   output logic [6:0]   segs4
);

   localparam int       CW      = $clog2(N + 1);
   localparam logic [6:0] c_blank = 7'h7F;
   localparam logic [6:0] c_dash  = 7'h3F;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_ENCODE = 2'd2
   } state_t;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = c_blank;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [N-1:0]      shreg_q, shreg_d;
   logic [19:0]       bcd_q, bcd_d;
   logic [CW-1:0]     count_q, count_d;
   logic [3:0][6:0]   segs_q, segs_d;
   logic              overflow_q, overflow_d;
   logic              done_q, done_d;

   logic [N-1:0]      w_load_val;
   logic [19:0]       w_bcd_adj;
   logic [3:0]        w_keep;
   logic              w_enc_ovf;
   logic [3:0][6:0]   w_enc_segs;

`ifdef SIGNED_DISPLAY_EN
   logic              neg_q, neg_d;
   // Magnitude is taken at load so the conversion length stays N cycles;
   // the most negative value maps to its unsigned magnitude (e.g. -128 -> 128).
   assign w_load_val = value[N-1] ? (~value + 1'b1) : value;
`else
   assign w_load_val = value;
`endif

   always_comb begin
      w_bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // w_keep[i] marks digits at or below the most significant nonzero digit.
   always_comb begin
      w_keep[3] = |bcd_q[15:12];
      w_keep[2] = w_keep[3] | (|bcd_q[11:8]);
      w_keep[1] = w_keep[2] | (|bcd_q[7:4]);
      w_keep[0] = 1'b1;
`ifdef SIGNED_DISPLAY_EN
      w_enc_ovf = (|bcd_q[19:16]) | (neg_q & w_keep[3]);
`else
      w_enc_ovf = |bcd_q[19:16];
`endif
      for (int i = 0; i < 4; i++) begin
         w_enc_segs[i] = w_keep[i] ? glyph(bcd_q[4*i +: 4]) : c_blank;
`ifdef SIGNED_DISPLAY_EN
         if (i > 0 && neg_q && !w_keep[i] && w_keep[i-1])
            w_enc_segs[i] = c_dash;
`endif
         if (w_enc_ovf)
            w_enc_segs[i] = c_dash;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bcd_d      = bcd_q;
      count_d    = count_q;
      segs_d     = segs_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
`ifdef SIGNED_DISPLAY_EN
      neg_d      = neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (load) begin
               shreg_d = w_load_val;
               bcd_d   = '0;
               count_d = CW'(N);
               state_d = S_SHIFT;
`ifdef SIGNED_DISPLAY_EN
               neg_d   = value[N-1];
`endif
            end
         end
         S_SHIFT: begin
            {bcd_d, shreg_d} = {w_bcd_adj, shreg_q} << 1;
            count_d          = count_q - 1'b1;
            if (count_q == CW'(1))
               state_d = S_ENCODE;
         end
         S_ENCODE: begin
            segs_d     = w_enc_segs;
            overflow_d = w_enc_ovf;
            done_d     = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         bcd_q      <= '0;
         count_q    <= '0;
         segs_q     <= {4{c_blank}};
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
         neg_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bcd_q      <= bcd_d;
         count_q    <= count_d;
         segs_q     <= segs_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
`ifdef SIGNED_DISPLAY_EN
         neg_q      <= neg_d;
`endif
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign overflow = overflow_q;
   assign segs1    = segs_q[0];
   assign segs2    = segs_q[1];
   assign segs3    = segs_q[2];
   assign segs4    = segs_q[3];

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_display.sv
// ============================================================================
// Module   : tb_bcd_seg_display
// Purpose  : Directed self-checking bench; 8-bit and 16-bit instances.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_seg_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  v8;
   logic        ld8;
   logic        busy8, done8, ovf8;
   logic [6:0]  s8_1, s8_2, s8_3, s8_4;
   logic [15:0] v16;
   logic        ld16;
   logic        busy16, done16, ovf16;
   logic [6:0]  s16_1, s16_2, s16_3, s16_4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bcd_seg_display #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .value(v8), .load(ld8),
      .busy(busy8), .done(done8), .overflow(ovf8),
      .segs1(s8_1), .segs2(s8_2), .segs3(s8_3), .segs4(s8_4)
   );

   bcd_seg_display #(.N(16)) u_dut16 (
      .clk(clk), .rst(rst), .value(v16), .load(ld16),
      .busy(busy16), .done(done16), .overflow(ovf16),
      .segs1(s16_1), .segs2(s16_2), .segs3(s16_3), .segs4(s16_4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [27:0] segs8();
      return {s8_4, s8_3, s8_2, s8_1};
   endfunction

   function automatic logic [27:0] segs16();
      return {s16_4, s16_3, s16_2, s16_1};
   endfunction

   // Load one value, measure load-to-done latency and busy continuity.
   task automatic run(input bit wide, input logic [15:0] val, input string tag);
      int lat;
      bit gap;
      @(negedge clk);
      if (wide) begin v16 = val; ld16 = 1'b1; end
      else      begin v8 = val[7:0]; ld8 = 1'b1; end
      @(negedge clk);
      ld8 = 1'b0; ld16 = 1'b0;
      lat = 0;
      gap = !(wide ? busy16 : busy8);
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (wide ? done16 : done8) break;
         if (!(wide ? busy16 : busy8)) gap = 1'b1;
      end
      check({tag, "_latency"}, lat, wide ? 17 : 9);
      check({tag, "_busy_gap"}, {31'd0, gap}, 0);
      @(negedge clk);
      check({tag, "_done_width"}, {31'd0, wide ? done16 : done8}, 0);
   endtask

   initial begin
      int ndone, lat2;
      bit gap;
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ndone, lat2;
      bit gap;
      rst = 1'b1; ld8 = 1'b0; ld16 = 1'b0; v8 = '0; v16 = '0;
      repeat (3) @(negedge clk);
      check("rst_flags8", {busy8, done8, ovf8}, 3'b000);
      check("rst_segs8", segs8(), {4{7'h7F}});
      check("rst_segs16", segs16(), {4{7'h7F}});
      rst = 1'b0;

      run(1'b0, 16'd45, "v45");
      check("v45_segs", segs8(), {7'h7F, 7'h7F, 7'h19, 7'h12});
      check("v45_ovf", ovf8, 0);

      run(1'b0, 16'd240, "v240");
`ifdef SIGNED_DISPLAY_EN
      check("v240_segs", segs8(), {7'h7F, 7'h3F, 7'h79, 7'h02});
`else
      check("v240_segs", segs8(), {7'h7F, 7'h24, 7'h19, 7'h40});
`endif

      run(1'b0, 16'd0, "v0");
      check("v0_segs", segs8(), {7'h7F, 7'h7F, 7'h7F, 7'h40});

      run(1'b0, 16'd255, "v255");
`ifdef SIGNED_DISPLAY_EN
      check("v255_segs", segs8(), {7'h7F, 7'h7F, 7'h3F, 7'h79});
`else
      check("v255_segs", segs8(), {7'h7F, 7'h24, 7'h12, 7'h12});
`endif

      // Second load three cycles into a conversion must be ignored.
      @(negedge clk); v8 = 8'd45; ld8 = 1'b1;
      @(negedge clk); ld8 = 1'b0;
      repeat (2) @(negedge clk);
      v8 = 8'd99; ld8 = 1'b1;
      @(negedge clk); ld8 = 1'b0;
      ndone = 0; gap = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done8) ndone++;
         else if (ndone == 0 && !busy8) gap = 1'b1;
      end
      check("ign_ndone", ndone, 1);
      check("ign_busy_gap", {31'd0, gap}, 0);
      check("ign_segs", segs8(), {7'h7F, 7'h7F, 7'h19, 7'h12});

      // Load held high restarts on the cycle after returning to IDLE.
      @(negedge clk); v8 = 8'd7; ld8 = 1'b1;
      ndone = 0;
      while (!done8 && ndone < 40) begin @(negedge clk); ndone++; end
      lat2 = 0;
      do begin @(negedge clk); lat2++; end while (!done8 && lat2 < 40);
      ld8 = 1'b0;
      check("held_period", lat2, 10);
      repeat (3) @(negedge clk);
      check("held_idle", busy8, 0);
      check("held_segs", segs8(), {7'h7F, 7'h7F, 7'h7F, 7'h78});

      // Asynchronous reset mid-conversion.
      @(negedge clk); v8 = 8'd99; ld8 = 1'b1;
      @(negedge clk); ld8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_busy", busy8, 0);
      check("arst_segs", segs8(), {4{7'h7F}});
      @(negedge clk); rst = 1'b0;
      ndone = 0; gap = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8) ndone++;
         if (busy8) gap = 1'b1;
      end
      check("arst_no_done", ndone, 0);
      check("arst_stays_idle", {31'd0, gap}, 0);

      run(1'b1, 16'd12345, "w12345");
      check("w12345_ovf", ovf16, 1);
      check("w12345_segs", segs16(), {4{7'h3F}});

      run(1'b1, 16'd9999, "w9999");
      check("w9999_ovf", ovf16, 0);
      check("w9999_segs", segs16(), {4{7'h10}});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
